// File: rtl/multicore_mm_pkg.sv
// Shared types and defaults for the multicore Avalon-MM command master.
package multicore_mm_pkg;

  localparam int unsigned DEF_ADDR_W = 2;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/multicore_mm_cmd_fifo.sv
// Show-ahead synchronous command FIFO with registered full/empty flags.
module multicore_mm_cmd_fifo
  import multicore_mm_pkg::*;
#(
  parameter int unsigned WIDTH = 35,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      count;
  logic [PW:0]      count_n;
  logic             full;
  logic             do_push;
  logic             do_pop;

  // A push while full is refused even if a pop happens in the same cycle,
  // because readiness comes from the registered flag, not the next count.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign ready   = ~full;
  assign dout    = mem[rd_ptr];

  // Next occupancy from this cycle's accepted push/pop.
  always_comb begin
    count_n = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // Storage array; contents need no reset since empty gates their use.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers (wrapping modulo DEPTH), occupancy and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      full  <= (count_n == (PW+1)'(DEPTH));
      empty <= (count_n == '0);
    end
  end

endmodule

// File: rtl/multicore_mm_cmd_master.sv
// Avalon-MM initiator: queued core commands become single-beat bus transfers,
// each answered by one response with timeout-to-error protection.
module multicore_mm_cmd_master
  import multicore_mm_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned FIFO_D  = 4,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_waitrequest,
  output logic              busy
);

  localparam int unsigned FW = 1 + ADDR_W + DATA_W;
  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     tmo_cnt;
  logic [CW-1:0]     tmo_cnt_n;
  logic [CW-1:0]     tmo_inc;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n;
  logic              rd_n;
  logic              wr_n;
  logic [DATA_W-1:0] rdata_n;
  logic              err_n;

  logic              fifo_pop;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_din;
  logic [FW-1:0]     fifo_dout;
  logic              head_write;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  assign fifo_din = {cmd_write, cmd_addr, cmd_wdata};
  assign {head_write, head_addr, head_wdata} = fifo_dout;

  multicore_mm_cmd_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_D)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .din   (fifo_din),
    .ready (cmd_ready),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty)
  );

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE) | ~fifo_empty;
  assign tmo_inc   = tmo_cnt + CW'(1);

  // Next-state, bus strobe/address and response register decisions.
  always_comb begin
    state_n   = state;
    tmo_cnt_n = tmo_cnt;
    addr_n    = avm_address;
    wdata_n   = avm_writedata;
    rd_n      = avm_read;
    wr_n      = avm_write;
    rdata_n   = rsp_rdata;
    err_n     = rsp_err;
    fifo_pop  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          addr_n    = head_addr;
          wdata_n   = head_wdata;
          rd_n      = ~head_write;
          wr_n      = head_write;
          tmo_cnt_n = '0;
          state_n   = BUS;
        end
      end
      BUS: begin
        if (!avm_waitrequest) begin
          rd_n    = 1'b0;
          wr_n    = 1'b0;
          rdata_n = avm_read ? avm_readdata : '0;
          err_n   = 1'b0;
          state_n = RESP;
        end else begin
          tmo_cnt_n = tmo_inc;
          if (tmo_inc == CW'(TMO_CYC)) begin
            rd_n    = 1'b0;
            wr_n    = 1'b0;
            rdata_n = '0;
            err_n   = 1'b1;
            state_n = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, timeout counter, bus outputs and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      avm_address   <= '0;
      avm_writedata <= '0;
      avm_read      <= 1'b0;
      avm_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      state         <= state_n;
      tmo_cnt       <= tmo_cnt_n;
      avm_address   <= addr_n;
      avm_writedata <= wdata_n;
      avm_read      <= rd_n;
      avm_write     <= wr_n;
      rsp_rdata     <= rdata_n;
      rsp_err       <= err_n;
    end
  end

endmodule

// File: tb/tb_multicore_mm_cmd_master.sv
// Directed self-checking bench for multicore_mm_cmd_master (TMO_CYC=8).
module tb_multicore_mm_cmd_master;
  import multicore_mm_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [1:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;

  int checks = 0;
  int errors = 0;

  multicore_mm_cmd_master #(
    .ADDR_W  (2),
    .DATA_W  (32),
    .FIFO_D  (4),
    .TMO_CYC (8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic w, input logic [1:0] a, input logic [31:0] d);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t tbl [5];
    int   n;
    logic extra;

    tbl[0] = '{write: 1'b1, addr: 2'd0, wdata: 32'h10};
    tbl[1] = '{write: 1'b1, addr: 2'd1, wdata: 32'h11};
    tbl[2] = '{write: 1'b1, addr: 2'd2, wdata: 32'h12};
    tbl[3] = '{write: 1'b1, addr: 2'd3, wdata: 32'h13};
    tbl[4] = '{write: 1'b1, addr: 2'd0, wdata: 32'hFF};

    reset = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; avm_readdata = '0; avm_waitrequest = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_strobes", {avm_read, avm_write}, 0);
    chk("rst_address", avm_address, 0);
    chk("rst_wdata", avm_writedata, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    tick();

    // Simple write, zero wait states
    push(1'b1, 2'd0, 32'h000000A5);
    chk("wr_busy", busy, 1);
    chk("wr_no_strobe_n1", avm_write, 0);
    tick();
    chk("wr_strobe", avm_write, 1);
    chk("wr_read_low", avm_read, 0);
    chk("wr_addr", avm_address, 0);
    chk("wr_data", avm_writedata, 32'hA5);
    tick();
    chk("wr_strobe_drop", avm_write, 0);
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_rsp_err", rsp_err, 0);
    chk("wr_rsp_rdata", rsp_rdata, 0);
    consume();
    chk("wr_rsp_done", rsp_valid, 0);
    chk("wr_idle", busy, 0);

    // Read with three stall cycles
    avm_waitrequest = 1'b1;
    avm_readdata = 32'hDEADBEEF;
    push(1'b0, 2'd0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("rd_stall_strobe", avm_read, 1);
      chk("rd_stall_addr", avm_address, 0);
      tick();
    end
    avm_waitrequest = 1'b0;
    avm_readdata = 32'h0000005A;
    chk("rd_final_strobe", avm_read, 1);
    tick();
    chk("rd_strobe_drop", avm_read, 0);
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rsp_rdata", rsp_rdata, 32'h5A);
    chk("rd_rsp_err", rsp_err, 0);

    // Response backpressure with a command waiting behind it
    avm_readdata = 32'h11111111;
    push(1'b1, 2'd1, 32'h33);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 32'h5A);
      chk("bp_err", rsp_err, 0);
      chk("bp_no_strobe", {avm_read, avm_write}, 0);
      tick();
    end
    consume();
    chk("bp_released", rsp_valid, 0);
    chk("bp_idle_no_strobe", avm_write, 0);
    tick();
    chk("bp_next_strobe", avm_write, 1);
    chk("bp_next_addr", avm_address, 1);
    chk("bp_next_data", avm_writedata, 32'h33);
    tick();
    chk("bp_next_rsp", rsp_valid, 1);
    chk("bp_next_rdata", rsp_rdata, 0);
    consume();

    // Timeout after 8 stall cycles
    avm_waitrequest = 1'b1;
    avm_readdata = 32'h77;
    push(1'b0, 2'd2, 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("tmo_strobe", avm_read, 1);
      chk("tmo_addr", avm_address, 2);
      tick();
    end
    chk("tmo_strobe_drop", avm_read, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_err", rsp_err, 1);
    chk("tmo_rsp_rdata", rsp_rdata, 0);
    avm_waitrequest = 1'b0;
    consume();
    push(1'b1, 2'd1, 32'h12345678);
    tick();
    chk("tmo_next_strobe", avm_write, 1);
    chk("tmo_next_data", avm_writedata, 32'h12345678);
    tick();
    chk("tmo_next_rsp", rsp_valid, 1);
    chk("tmo_next_err", rsp_err, 0);
    consume();

    // FIFO full while the FSM is parked in RESP
    push(1'b0, 2'd1, 32'h0);
    tick(); tick();
    chk("full_parked", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      cmd_write = tbl[k].write;
      cmd_addr  = tbl[k].addr;
      cmd_wdata = tbl[k].wdata;
      cmd_valid = 1'b1;
      chk("full_cmd_ready", cmd_ready, (k < 4) ? 1 : 0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_refused", cmd_ready, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!avm_write && n < 12) begin
        tick();
        n++;
      end
      chk("full_strobe_seen", avm_write, 1);
      chk("full_gap", n, 2);
      chk("full_order_addr", avm_address, tbl[k].addr);
      chk("full_order_data", avm_writedata, tbl[k].wdata);
      tick();
    end
    extra = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (avm_write || avm_read) extra = 1'b1;
      tick();
    end
    rsp_ready = 1'b0;
    chk("full_no_fifth", extra, 0);
    chk("full_drained", busy, 0);

    // Asynchronous reset in the middle of a stalled write
    avm_waitrequest = 1'b1;
    push(1'b1, 2'd3, 32'hCAFE);
    push(1'b1, 2'd2, 32'hBEEF);
    chk("mid_strobe", avm_write, 1);
    chk("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_strobe", avm_write, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    avm_waitrequest = 1'b0;
    tick();
    reset = 1'b0;
    extra = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (avm_write || avm_read || rsp_valid) extra = 1'b1;
    end
    chk("mid_after_quiet", extra, 0);
    chk("mid_after_ready", cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
